// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the miss/fill responder: FSM state
//                encoding, requester side encoding and a line-align helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

   // FSM state encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WB   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   localparam logic [1:0] FILL = 2'd3;

   // Which cache the current transaction belongs to
   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   // Clear the word-offset bits of a word address; lineWords is a power of two.
   // Works on a wide container so callers of any address width can cast down.
   function automatic logic [63:0] lineAlign(input logic [63:0] addr, input int lineWords);
      return addr & ~(64'(lineWords) - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0  initial release
//  Ports       : clk   in   clock
//                rst   in   asynchronous active-high reset (count -> 0)
//                inc   in   increment request for this cycle
//                count out  current count
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/miss_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : miss_fill_ctrl
//  Description : Services I-cache and D-cache line misses. Arbitrates the two
//                sources (D first), writes back a dirty D victim, reads the
//                missing line from the unified memory and pulses a one-cycle
//                fill strobe to the requesting cache.
//  Revision    : 1.0  initial release
//  Ports       : clk, rst                      clock / async active-high reset
//                i_miss, i_addr                I-cache miss level + word address
//                d_miss, d_addr                D-cache miss level + word address
//                d_victim_dirty/_addr/_data    D victim line description
//                fill_data                     line returned from memory
//                i_fill_we, d_fill_we          one-cycle fill strobes
//                mem_re, mem_we, mem_addr,
//                mem_wdata, mem_rdata, mem_rdy line-wide memory request port
//                busy                          transaction in progress
//                i_miss_cnt, d_miss_cnt        saturating serviced-miss counts
// ============================================================================
module miss_fill_ctrl
   import mem_pkg::*;
#(
   parameter int WORD_W     = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 16,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_miss,
   input  logic [ADDR_W-1:0]            i_addr,
   input  logic                         d_miss,
   input  logic [ADDR_W-1:0]            d_addr,
   input  logic                         d_victim_dirty,
   input  logic [ADDR_W-1:0]            d_victim_addr,
   input  logic [WORD_W*LINE_WORDS-1:0] d_victim_data,
   output logic [WORD_W*LINE_WORDS-1:0] fill_data,
   output logic                         i_fill_we,
   output logic                         d_fill_we,
   output logic                         mem_re,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [WORD_W*LINE_WORDS-1:0] mem_wdata,
   input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
   input  logic                         mem_rdy,
   output logic                         busy,
   output logic [CNT_W-1:0]             i_miss_cnt,
   output logic [CNT_W-1:0]             d_miss_cnt
);

   localparam int LINE_W = WORD_W * LINE_WORDS;

   logic [1:0]        r_state;
   logic [1:0]        w_nextState;
   logic              r_side;
   logic [ADDR_W-1:0] r_missLine;
   logic [ADDR_W-1:0] r_victimLine;
   logic [LINE_W-1:0] r_victimData;
   logic [LINE_W-1:0] r_fillData;

   logic [ADDR_W-1:0] w_dLine;
   logic [ADDR_W-1:0] w_iLine;
   logic [ADDR_W-1:0] w_victimLine;
   logic              w_incI;
   logic              w_incD;

   assign w_dLine      = ADDR_W'(lineAlign(64'(d_addr), LINE_WORDS));
   assign w_iLine      = ADDR_W'(lineAlign(64'(i_addr), LINE_WORDS));
   assign w_victimLine = ADDR_W'(lineAlign(64'(d_victim_addr), LINE_WORDS));

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ----------------------------------------------------------- next state
   // The victim dirty flag is consumed at accept time: it alone decides
   // whether the transaction starts with a write-back phase.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (d_miss) begin
               w_nextState = d_victim_dirty ? WB : RD;
            end else if (i_miss) begin
               w_nextState = RD;
            end
         end
         WB:      if (mem_rdy) w_nextState = RD;
         RD:      if (mem_rdy) w_nextState = FILL;
         FILL:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // -------------------------------------------------------- request latch
   // Everything the transaction needs is captured on accept so the
   // requester may flush (drop the miss) or change its inputs mid-service.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_side       <= SIDE_I;
         r_missLine   <= '0;
         r_victimLine <= '0;
         r_victimData <= '0;
         r_fillData   <= '0;
      end else begin
         if (r_state == IDLE) begin
            if (d_miss) begin
               r_side       <= SIDE_D;
               r_missLine   <= w_dLine;
               r_victimLine <= w_victimLine;
               r_victimData <= d_victim_data;
            end else if (i_miss) begin
               r_side     <= SIDE_I;
               r_missLine <= w_iLine;
            end
         end
         if ((r_state == RD) && mem_rdy) begin
            r_fillData <= mem_rdata;
         end
      end
   end

   // --------------------------------------------------------- output decode
   // Request outputs are a pure function of state and latched data, so they
   // stay stable for the whole request and drop at once on reset.
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_fill_we = 1'b0;
      d_fill_we = 1'b0;
      case (r_state)
         WB: begin
            mem_we    = 1'b1;
            mem_addr  = r_victimLine;
            mem_wdata = r_victimData;
         end
         RD: begin
            mem_re   = 1'b1;
            mem_addr = r_missLine;
         end
         FILL: begin
            i_fill_we = (r_side == SIDE_I);
            d_fill_we = (r_side == SIDE_D);
         end
         default: ;
      endcase
   end

   assign busy      = (r_state != IDLE);
   assign fill_data = r_fillData;

   // ------------------------------------------------------------- counters
   assign w_incI = (r_state == FILL) && (r_side == SIDE_I);
   assign w_incD = (r_state == FILL) && (r_side == SIDE_D);

   sat_counter #(.CNT_W(CNT_W)) u_iCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_incI),
      .count (i_miss_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_dCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_incD),
      .count (d_miss_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_miss_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miss_fill_ctrl
//  Description : Self-checking bench for miss_fill_ctrl. A transaction-level
//                model turns each accepted miss into the list of bus cycles
//                it must produce, and keeps a line-granular memory image.
//                Narrow counters keep the saturation run short.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_miss_fill_ctrl;

   localparam int          CW   = 8;
   localparam int unsigned CMAX = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_miss, d_miss, d_victim_dirty, mem_rdy;
   logic [15:0] i_addr, d_addr, d_victim_addr;
   logic [63:0] d_victim_data, mem_rdata;
   logic [63:0] fill_data, mem_wdata;
   logic        i_fill_we, d_fill_we, mem_re, mem_we, busy;
   logic [15:0] mem_addr;
   logic [CW-1:0] i_miss_cnt, d_miss_cnt;

   always #5 clk = ~clk;

   miss_fill_ctrl #(.WORD_W(16), .LINE_WORDS(4), .ADDR_W(16), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .i_miss(i_miss), .i_addr(i_addr),
      .d_miss(d_miss), .d_addr(d_addr),
      .d_victim_dirty(d_victim_dirty), .d_victim_addr(d_victim_addr),
      .d_victim_data(d_victim_data),
      .fill_data(fill_data), .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
      .busy(busy), .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
   );

   // One expected bus cycle of a transaction
   typedef struct {
      bit          re;
      bit          we;
      bit          iFill;
      bit          dFill;
      bit          rdy;
      logic [15:0] addr;
      logic [63:0] wdata;
   } busCycle_t;

   busCycle_t   sched[$];
   logic [63:0] memArr [logic [15:0]];
   int unsigned expI, expD;
   logic [63:0] expFill;
   int          nChecks = 0, nFail = 0, cyc = 0;

   // stimulus intent for the next tick
   logic        sD, sI, sDirty;
   logic [15:0] sDA, sIA, sVA;
   logic [63:0] sVD;
   int          sWbLat, sRdLat;

   // observations used by the hand-computed literal checks
   int          obsRe, obsWe, obsDFill, obsIFill, dFillCyc, iFillCyc, acceptCyc;
   logic [15:0] obsReAddr, obsWeAddr;
   logic [63:0] obsWeData;

   function automatic busCycle_t blank();
      busCycle_t c;
      c.re = 1'b0; c.we = 1'b0; c.iFill = 1'b0; c.dFill = 1'b0; c.rdy = 1'b0;
      c.addr = '0; c.wdata = '0;
      return c;
   endfunction

   // Untouched lines hold an address-derived pattern
   function automatic logic [63:0] memRead(input logic [15:0] a);
      if (memArr.exists(a)) return memArr[a];
      return {a, ~a, a ^ 16'h5a5a, a + 16'd1};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clearObs();
      obsRe = 0; obsWe = 0; obsDFill = 0; obsIFill = 0;
      dFillCyc = -1; iFillCyc = -1; acceptCyc = -1;
      obsReAddr = '0; obsWeAddr = '0; obsWeData = '0;
   endtask

   task automatic compareOutputs();
      busCycle_t e;
      bit        active;
      active = (sched.size() > 0);
      e = active ? sched[0] : blank();
      chk("busy", busy, active);
      chk("mem_re", mem_re, e.re);
      chk("mem_we", mem_we, e.we);
      if (e.re || e.we) chk("mem_addr", mem_addr, e.addr);
      if (e.we)         chk("mem_wdata", mem_wdata, e.wdata);
      chk("i_fill_we", i_fill_we, e.iFill);
      chk("d_fill_we", d_fill_we, e.dFill);
      if (e.iFill || e.dFill) chk("fill_data", fill_data, expFill);
      chk("i_miss_cnt", i_miss_cnt, expI);
      chk("d_miss_cnt", d_miss_cnt, expD);
      if (mem_re === 1'b1) begin obsRe++; obsReAddr = mem_addr; end
      if (mem_we === 1'b1) begin obsWe++; obsWeAddr = mem_addr; obsWeData = mem_wdata; end
      if (d_fill_we === 1'b1) begin obsDFill++; dFillCyc = cyc; end
      if (i_fill_we === 1'b1) begin obsIFill++; iFillCyc = cyc; end
   endtask

   // A miss accepted now owes: optional write-back, the read, one fill cycle
   task automatic buildSched();
      busCycle_t   c;
      bit          isD;
      logic [15:0] line;
      isD  = sD;
      line = (isD ? sDA : sIA) & 16'hFFFC;
      if (isD && sDirty) begin
         for (int k = 0; k <= sWbLat; k++) begin
            c = blank(); c.we = 1'b1; c.addr = sVA & 16'hFFFC; c.wdata = sVD;
            c.rdy = (k == sWbLat);
            sched.push_back(c);
         end
      end
      for (int k = 0; k <= sRdLat; k++) begin
         c = blank(); c.re = 1'b1; c.addr = line; c.rdy = (k == sRdLat);
         sched.push_back(c);
      end
      c = blank(); c.iFill = !isD; c.dFill = isD;
      sched.push_back(c);
   endtask

   // One clock: check this cycle, then drive inputs for the coming edge
   task automatic tick();
      busCycle_t e;
      @(negedge clk);
      cyc++;
      compareOutputs();
      d_miss = sD; i_miss = sI; d_addr = sDA; i_addr = sIA;
      d_victim_dirty = sDirty; d_victim_addr = sVA; d_victim_data = sVD;
      mem_rdy   = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      if (sched.size() == 0) begin
         if (sD || sI) begin
            acceptCyc = cyc;
            buildSched();
         end
      end else begin
         e = sched.pop_front();
         if (e.re || e.we) mem_rdy = e.rdy;
         if (e.we && e.rdy) memArr[e.addr] = e.wdata;
         if (e.re && e.rdy) begin
            mem_rdata = memRead(e.addr);
            expFill   = mem_rdata;
         end
         if (e.iFill && expI < CMAX) expI++;
         if (e.dFill && expD < CMAX) expD++;
      end
   endtask

   task automatic drain();
      while (sched.size() > 0) tick();
   endtask

   task automatic applyReset();
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_re", mem_re, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_i_fill_we", i_fill_we, 1'b0);
      chk("rst_d_fill_we", d_fill_we, 1'b0);
      chk("rst_fill_data", fill_data, 64'h0);
      chk("rst_i_cnt", i_miss_cnt, 8'h0);
      chk("rst_d_cnt", d_miss_cnt, 8'h0);
      sched.delete();
      expI = 0; expD = 0; expFill = '0;
      sD = 1'b0; sI = 1'b0; sDirty = 1'b0;
      i_miss = 1'b0; d_miss = 1'b0; d_victim_dirty = 1'b0; mem_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_miss = 1'b0; d_miss = 1'b0; d_victim_dirty = 1'b0; mem_rdy = 1'b0;
      i_addr = '0; d_addr = '0; d_victim_addr = '0; d_victim_data = '0; mem_rdata = '0;
      sD = 1'b0; sI = 1'b0; sDirty = 1'b0; sDA = '0; sIA = '0; sVA = '0; sVD = '0;
      sWbLat = 0; sRdLat = 0;
      clearObs();
      applyReset();

      // Clean D miss, memory ready on the fourth request cycle
      clearObs();
      sD = 1'b1; sDA = 16'h0123; sDirty = 1'b0; sRdLat = 3;
      tick(); drain();
      sD = 1'b0; tick();
      chk("t1_re_cycles", obsRe, 4);
      chk("t1_re_addr", obsReAddr, 16'h0120);
      chk("t1_strobes", obsDFill, 1);
      chk("t1_latency", dFillCyc - acceptCyc, 5);
      chk("t1_d_cnt", d_miss_cnt, 8'd1);

      // Dirty D miss: write-back, then read, then strobe
      clearObs();
      sD = 1'b1; sDA = 16'h0040; sDirty = 1'b1; sVA = 16'h8043;
      sVD = 64'hDEAD_BEEF_0123_4567; sWbLat = 1; sRdLat = 0;
      tick(); drain();
      sD = 1'b0; sDirty = 1'b0; tick();
      chk("t2_we_addr", obsWeAddr, 16'h8040);
      chk("t2_we_data", obsWeData, 64'hDEAD_BEEF_0123_4567);
      chk("t2_we_cycles", obsWe, 2);
      chk("t2_re_addr", obsReAddr, 16'h0040);
      chk("t2_strobes", obsDFill, 1);
      chk("t2_d_cnt", d_miss_cnt, 8'd2);

      // Both sources in the same cycle: D first, I on the IDLE after D's fill
      applyReset();
      clearObs();
      sD = 1'b1; sI = 1'b1; sDA = 16'h0200; sIA = 16'h0301; sRdLat = 1;
      tick(); drain();
      sD = 1'b0; sRdLat = 0;
      tick(); drain();
      sI = 1'b0; tick();
      chk("t3_d_strobes", obsDFill, 1);
      chk("t3_i_strobes", obsIFill, 1);
      chk("t3_i_accept", acceptCyc - dFillCyc, 1);
      chk("t3_min_service", iFillCyc - acceptCyc, 2);
      chk("t3_i_cnt", i_miss_cnt, 8'd1);
      chk("t3_d_cnt", d_miss_cnt, 8'd1);

      // Reset while waiting in write-back, then a clean I miss
      clearObs();
      sD = 1'b1; sDA = 16'h0500; sDirty = 1'b1; sVA = 16'h0900; sVD = 64'h1111_2222_3333_4444;
      sWbLat = 20; sRdLat = 0;
      tick(); tick(); tick();
      #2;
      applyReset();
      chk("t4_no_strobe", obsDFill, 0);
      clearObs();
      sI = 1'b1; sIA = 16'h0777; sRdLat = 1;
      tick(); drain();
      sI = 1'b0; tick();
      chk("t4_i_strobes", obsIFill, 1);
      chk("t4_re_addr", obsReAddr, 16'h0774);
      chk("t4_i_cnt", i_miss_cnt, 8'd1);

      // I miss dropped while its read is outstanding
      clearObs();
      sI = 1'b1; sIA = 16'h1235; sRdLat = 3;
      tick();
      sI = 1'b0;
      drain();
      repeat (3) tick();
      chk("t6_i_strobes", obsIFill, 1);
      chk("t6_re_cycles", obsRe, 4);
      chk("t6_re_addr", obsReAddr, 16'h1234);
      chk("t6_busy", busy, 1'b0);

      // Saturation: back-to-back I misses with memory always ready
      applyReset();
      sI = 1'b1; sRdLat = 0;
      for (int n = 0; n < 780; n++) begin
         sIA = 16'($urandom);
         tick();
      end
      sI = 1'b0; drain(); tick();
      chk("t5_sat", i_miss_cnt, 8'hFF);
      clearObs();
      sI = 1'b1; tick(); sI = 1'b0; drain(); tick();
      chk("t5_sat_strobe", obsIFill, 1);
      chk("t5_sat_hold", i_miss_cnt, 8'hFF);

      // Randomized traffic over a small address range so victims collide
      applyReset();
      for (int n = 0; n < 1500; n++) begin
         sD     = ($urandom_range(0, 3) == 0);
         sI     = ($urandom_range(0, 2) == 0);
         sDA    = 16'($urandom_range(0, 63));
         sIA    = 16'($urandom_range(0, 63));
         sDirty = 1'($urandom_range(0, 1));
         sVA    = ($urandom_range(0, 3) == 0) ? (sDA ^ 16'($urandom_range(0, 3)))
                                              : 16'($urandom_range(0, 63));
         sVD    = {$urandom, $urandom};
         sWbLat = $urandom_range(0, 3);
         sRdLat = $urandom_range(0, 3);
         tick();
      end
      sD = 1'b0; sI = 1'b0;
      drain(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
`default_nettype wire
